// File: rtl/sys_defs.sv
// Shared definitions for the fetch/decode boundary: instruction queue entry
// layout, default queue depth and the NOOP encoding shown on an empty head.
package sys_defs;

  localparam int          IFQ_DEPTH = 4;
  localparam logic [31:0] NOOP_INST = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] PC;
    logic [31:0] NPC;
    logic [31:0] IR;
  } ifq_entry_t;

endpackage

// File: rtl/ifq_storage.sv
// Entry storage for the IF/ID queue: one synchronous write port and one
// asynchronous read port. Contents are not reset.
module ifq_storage
  import sys_defs::*;
#(
  parameter int DEPTH = IFQ_DEPTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  ifq_entry_t    wdata_i,
  input  logic [AW-1:0] raddr_i,
  output ifq_entry_t    rdata_o
);

  ifq_entry_t mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/if_id_queue.sv
// Circular instruction queue between fetch and decode; flush on taken branch.
// Optional macro IFQ_BYPASS_EN lets a fetch into an empty queue reach decode combinationally.
module if_id_queue
  import sys_defs::*;
#(
  parameter int DEPTH = IFQ_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     if_valid_inst_in,
  input  logic [31:0]              if_PC_in,
  input  logic [31:0]              if_NPC_in,
  input  logic [31:0]              if_IR_in,
  input  logic                     id_hazard_flag,
  input  logic                     ex_take_branch_out,
  output logic                     ifq_full,
  output logic [31:0]              ifq_PC_out,
  output logic [31:0]              ifq_NPC_out,
  output logic [31:0]              ifq_IR_out,
  output logic                     ifq_valid_inst_out,
  output logic [$clog2(DEPTH):0]   ifq_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          empty, enq, deq, byp, wr_en;
  ifq_entry_t    head, wdata;

  assign empty    = (count_q == '0);
  assign ifq_full = (count_q == CW'(DEPTH));
  assign enq      = if_valid_inst_in && !ifq_full && !ex_take_branch_out;
  assign deq      = !empty && !id_hazard_flag && !ex_take_branch_out;

`ifdef IFQ_BYPASS_EN
  assign byp = empty && if_valid_inst_in && !ex_take_branch_out;
`else
  assign byp = 1'b0;
`endif

  // A bypassed instruction that decode consumes immediately never lands in storage.
  assign wr_en = enq && !(byp && !id_hazard_flag);

  assign wdata = '{PC: if_PC_in, NPC: if_NPC_in, IR: if_IR_in};

  ifq_storage #(.DEPTH(DEPTH)) u_storage (
    .clk     (clk),
    .we_i    (wr_en && !rst),
    .waddr_i (wr_ptr_q),
    .wdata_i (wdata),
    .raddr_i (rd_ptr_q),
    .rdata_o (head)
  );

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (ex_take_branch_out) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_en) wr_ptr_d = wr_ptr_q + PW'(1);
      if (deq)   rd_ptr_d = rd_ptr_q + PW'(1);
      case ({wr_en, deq})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  always_comb begin
    ifq_valid_inst_out = 1'b0;
    ifq_PC_out         = '0;
    ifq_NPC_out        = '0;
    ifq_IR_out         = NOOP_INST;
    if (byp) begin
      ifq_valid_inst_out = 1'b1;
      ifq_PC_out         = if_PC_in;
      ifq_NPC_out        = if_NPC_in;
      ifq_IR_out         = if_IR_in;
    end else if (!empty) begin
      ifq_valid_inst_out = 1'b1;
      ifq_PC_out         = head.PC;
      ifq_NPC_out        = head.NPC;
      ifq_IR_out         = head.IR;
    end
  end

  assign ifq_count = count_q;

endmodule
